// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: baud divisor table, parity modes and FSM states.
package uart_pkg;

  localparam int unsigned ParityNone = 0;
  localparam int unsigned ParityEven = 1;
  localparam int unsigned ParityOdd  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // sysclk cycles per 16x oversample tick
  function automatic int unsigned br_divisor(input logic [2:0] br);
    case (br)
      3'b000:  return 15;
      3'b001:  return 7;
      3'b010:  return 4;
      3'b011:  return 2;
      default: return 15;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word-fall-through FIFO; rdata_o is registered and holds the last head when empty.
module uart_rx_fifo #(
  parameter int unsigned Width     = 8,
  parameter int unsigned DepthBits = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned Depth = 1 << DepthBits;
  localparam int unsigned PtrW  = DepthBits + 1;

  logic [PtrW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [Width-1:0]     mem_q [Depth];
  logic [Width-1:0]     rdata_q, rdata_d;
  logic [DepthBits-1:0] nxt_idx;
  logic                 push_eff, pop_eff, one_left;

  assign empty_o  = (wr_q == rd_q);
  assign full_o   = (wr_q[DepthBits] != rd_q[DepthBits]) &&
                    (wr_q[DepthBits-1:0] == rd_q[DepthBits-1:0]);
  assign pop_eff  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the same cycle pops
  assign push_eff = push_i && (!full_o || pop_eff);
  assign nxt_idx  = rd_q[DepthBits-1:0] + DepthBits'(1);
  assign one_left = ((rd_q + PtrW'(1)) == wr_q);
  assign rdata_o  = rdata_q;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    if (push_eff) wr_d = wr_q + PtrW'(1);
    if (pop_eff) begin
      rd_d = rd_q + PtrW'(1);
      if (one_left) begin
        if (push_eff) rdata_d = wdata_i;
      end else begin
        rdata_d = mem_q[nxt_idx];
      end
    end else if (push_eff && empty_o) begin
      rdata_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wr_q[DepthBits-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver with 16x oversampling, optional parity and an output FIFO with error pulses.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned data_bits       = 8,
  parameter logic [2:0]  br              = 3'b000,
  parameter int unsigned parity_mode     = 0,
  parameter int unsigned fifo_depth_bits = 2
) (
  input  logic                 sysclk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 rd_en,
  output logic [data_bits-1:0] rdata,
  output logic                 rx_valid,
  output logic                 fifo_full,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int unsigned Div = br_divisor(br);

  logic                 sync1_q, rxd_s, rxd_last_q;
  logic [3:0]           div_q, div_d;
  logic                 tick;
  uart_state_e          state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [data_bits-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 ferr_q, ferr_d, perr_q, perr_d, oerr_q, oerr_d;
  logic                 push, fifo_empty, exp_par;

  assign tick  = (div_q == 4'(Div - 1));
  assign div_d = tick ? 4'd0 : div_q + 4'd1;

  assign exp_par = (^shift_q) ^ (parity_mode == ParityOdd);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    push      = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    oerr_d    = 1'b0;
    case (state_q)
      StIdle: begin
        // rxd_last_q makes a line that stays low after a frame unable to retrigger
        if (rxd_last_q && !rxd_s) begin
          state_d = StStart;
          cnt_d   = 4'd0;
        end
      end
      StStart: begin
        if (tick) begin
          if (cnt_q == 4'd7) begin
            cnt_d     = 4'd0;
            bit_d     = 3'd0;
            par_bad_d = 1'b0;
            state_d   = rxd_s ? StIdle : StData;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (cnt_q == 4'd15) begin
            cnt_d   = 4'd0;
            shift_d = {rxd_s, shift_q[data_bits-1:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'(data_bits - 1)) begin
              state_d = (parity_mode == ParityNone) ? StStop : StParity;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          if (cnt_q == 4'd15) begin
            cnt_d     = 4'd0;
            par_bad_d = (rxd_s != exp_par);
            state_d   = StStop;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (cnt_q == 4'd15) begin
            cnt_d   = 4'd0;
            state_d = StIdle;
            if (!rxd_s)                   ferr_d = 1'b1;
            else if (par_bad_q)           perr_d = 1'b1;
            else if (fifo_full && !rd_en) oerr_d = 1'b1;
            else                          push   = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxd_s      <= 1'b1;
      rxd_last_q <= 1'b1;
      div_q      <= 4'd0;
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      bit_q      <= 3'd0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      oerr_q     <= 1'b0;
    end else begin
      sync1_q    <= rxd;
      rxd_s      <= sync1_q;
      rxd_last_q <= rxd_s;
      div_q      <= div_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_bad_q  <= par_bad_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      oerr_q     <= oerr_d;
    end
  end

  uart_rx_fifo #(
    .Width     (data_bits),
    .DepthBits (fifo_depth_bits)
  ) u_fifo (
    .clk_i   (sysclk),
    .rst_i   (rst),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (rd_en),
    .rdata_o (rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rx_valid    = !fifo_empty;
  assign frame_err   = ferr_q;
  assign parity_err  = perr_q;
  assign overrun_err = oerr_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: frames, parity/framing errors, overrun, glitch and reset.
module tb_uart_rx_buffered;

  localparam int BitClks = 240;

  logic       sysclk = 1'b0;
  logic       rst, rxd, rxd_p, rd_en, rd_en_p;
  logic [7:0] rdata, rdata_p;
  logic       rx_valid, fifo_full, frame_err, parity_err, overrun_err;
  logic       rx_valid_p, fifo_full_p, frame_err_p, parity_err_p, overrun_err_p;

  int n_asserts = 0;
  int n_fail    = 0;
  int n_ferr = 0, n_perr = 0, n_oerr = 0, n_perr_p = 0, n_ferr_p = 0;
  logic [7:0] exp_q[$];

  always #5 sysclk = ~sysclk;

  uart_rx_buffered dut (
    .sysclk(sysclk), .rst(rst), .rxd(rxd), .rd_en(rd_en), .rdata(rdata),
    .rx_valid(rx_valid), .fifo_full(fifo_full), .frame_err(frame_err),
    .parity_err(parity_err), .overrun_err(overrun_err)
  );

  uart_rx_buffered #(.parity_mode(1)) dut_p (
    .sysclk(sysclk), .rst(rst), .rxd(rxd_p), .rd_en(rd_en_p), .rdata(rdata_p),
    .rx_valid(rx_valid_p), .fifo_full(fifo_full_p), .frame_err(frame_err_p),
    .parity_err(parity_err_p), .overrun_err(overrun_err_p)
  );

  always @(posedge sysclk) begin
    if (frame_err)    n_ferr   <= n_ferr + 1;
    if (parity_err)   n_perr   <= n_perr + 1;
    if (overrun_err)  n_oerr   <= n_oerr + 1;
    if (parity_err_p) n_perr_p <= n_perr_p + 1;
    if (frame_err_p)  n_ferr_p <= n_ferr_p + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input bit to_p, input logic b);
    if (to_p) rxd_p = b;
    else      rxd   = b;
    repeat (BitClks) @(posedge sysclk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit to_p, input bit with_par,
                            input logic par, input logic stop);
    drive_bit(to_p, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(to_p, d[i]);
    if (with_par) drive_bit(to_p, par);
    drive_bit(to_p, stop);
    drive_bit(to_p, 1'b1);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    @(negedge sysclk);
    check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, rdata}, {24'd0, e});
    rd_en = 1'b1;
    @(posedge sysclk);
    #1 rd_en = 1'b0;
  endtask

  initial begin
    int f0, p0, o0;
    logic [7:0] d;
    rst = 1'b1; rxd = 1'b1; rxd_p = 1'b1; rd_en = 1'b0; rd_en_p = 1'b0;
    repeat (5) @(posedge sysclk);
    @(negedge sysclk);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_full", {31'd0, fifo_full}, 32'd0);
    check("rst_errs", {29'd0, frame_err, parity_err, overrun_err}, 32'd0);
    rst = 1'b0;
    repeat (50) @(posedge sysclk);

    // Clean frame
    f0 = n_ferr; p0 = n_perr; o0 = n_oerr;
    exp_q.push_back(8'hFD);
    send_frame(8'hFD, 1'b0, 1'b0, 1'b0, 1'b1);
    pop_check("fd");
    @(negedge sysclk);
    check("fd_empty", {31'd0, rx_valid}, 32'd0);
    check("fd_hold", {24'd0, rdata}, 32'hFD);
    check("fd_errs", n_ferr + n_perr + n_oerr - f0 - p0 - o0, 32'd0);

    // Even parity: A5 has even ones so parity bit 1 is wrong
    p0 = n_perr_p;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge sysclk);
    check("par_pulse", n_perr_p - p0, 32'd1);
    check("par_novalid", {31'd0, rx_valid_p}, 32'd0);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge sysclk);
    check("par_ok_valid", {31'd0, rx_valid_p}, 32'd1);
    check("par_ok_data", {24'd0, rdata_p}, 32'hA5);
    check("par_ok_noerr", n_perr_p + n_ferr_p - p0, 32'd1);

    // Framing error
    f0 = n_ferr; p0 = n_perr;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge sysclk);
    check("ferr_pulse", n_ferr - f0, 32'd1);
    check("ferr_noperr", n_perr - p0, 32'd0);
    check("ferr_empty", {31'd0, rx_valid}, 32'd0);

    // Fill and overrun
    for (int i = 1; i <= 5; i++) begin
      o0 = n_oerr;
      d = 8'(i);
      if (exp_q.size() < 4) exp_q.push_back(d);
      send_frame(d, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge sysclk);
      check($sformatf("full_%0d", i), {31'd0, fifo_full}, {31'd0, exp_q.size() == 4});
      check($sformatf("ovr_%0d", i), n_oerr - o0, (i == 5) ? 32'd1 : 32'd0);
    end
    for (int i = 1; i <= 4; i++) pop_check($sformatf("pop_%0d", i));
    @(negedge sysclk);
    check("drain_valid", {31'd0, rx_valid}, 32'd0);
    check("drain_hold", {24'd0, rdata}, 32'h04);

    // Short low glitch
    f0 = n_ferr; p0 = n_perr; o0 = n_oerr;
    rxd = 1'b0;
    repeat (100) @(posedge sysclk);
    rxd = 1'b1;
    repeat (3000) @(posedge sysclk);
    @(negedge sysclk);
    check("glitch_valid", {31'd0, rx_valid}, 32'd0);
    check("glitch_errs", n_ferr + n_perr + n_oerr - f0 - p0 - o0, 32'd0);

    // Reset in the middle of a 55 frame
    f0 = n_ferr; p0 = n_perr; o0 = n_oerr;
    d = 8'h55;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, d[i]);
    #1 rst = 1'b1;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    check("midrst_rdata", {24'd0, rdata}, 32'd0);
    rxd = 1'b1;
    repeat (2) @(posedge sysclk);
    #1 rst = 1'b0;
    repeat (3000) @(posedge sysclk);
    @(negedge sysclk);
    check("midrst_novalid", {31'd0, rx_valid}, 32'd0);
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
    pop_check("after_rst");
    @(negedge sysclk);
    check("after_rst_empty", {31'd0, rx_valid}, 32'd0);
    check("after_rst_errs", n_ferr + n_perr + n_oerr - f0 - p0 - o0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
